// File: rtl/car_detect.sv
// Purpose: debounce a country-road loop sensor, count waiting cars, raise X and flag a stuck sensor.
// Latency: filtered level follows a clean loop_in edge after DEBOUNCE+2 edges; X tracks demand combinationally, then holds HOLD edges.
// Backpressure: none; a free-running monitor that samples every clock and never stalls.
module car_detect #(
    parameter int DEBOUNCE    = 4,
    parameter int HOLD        = 8,
    parameter int STUCK_LIMIT = 100
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       loop_in,
    input  logic [1:0] cntry,
    output logic       X,
    output logic [3:0] car_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } deb_state_t;

    localparam logic [2:0] DEB_LAST    = 3'(DEBOUNCE - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD);
    localparam logic [6:0] STUCK_MAX   = 7'(STUCK_LIMIT);
    localparam logic [1:0] CNTRY_GREEN = 2'd2;

    logic       r_s1;
    logic       r_s2;
    deb_state_t r_state;
    logic [2:0] r_deb_cnt;
    logic [3:0] r_car_count;
    logic [3:0] r_hold_cnt;
    logic [6:0] r_stuck_cnt;
    logic       r_fault;

    deb_state_t w_next_state;
    logic [2:0] w_next_deb_cnt;
    logic       w_filtered;
    logic       w_arrival;
    logic       w_departure;
    logic       w_green;
    logic       w_demand;
    logic       w_fault_set;

    // 2-flop synchronizer; only the second stage feeds the debouncer
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= loop_in;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM state and qualification counter
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= ST_LOW;
            r_deb_cnt <= 3'd0;
        end else begin
            r_state   <= w_next_state;
            r_deb_cnt <= w_next_deb_cnt;
        end
    end

    // Next-state: a level must persist DEBOUNCE samples before it is accepted
    always_comb begin
        w_next_state   = r_state;
        w_next_deb_cnt = r_deb_cnt;
        case (r_state)
            ST_LOW: begin
                if (r_s2) begin
                    w_next_state   = ST_RISE_CHK;
                    w_next_deb_cnt = 3'd1;
                end
            end
            ST_RISE_CHK: begin
                if (!r_s2) begin
                    w_next_state = ST_LOW;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_next_state = ST_HIGH;
                end else begin
                    w_next_deb_cnt = r_deb_cnt + 3'd1;
                end
            end
            ST_HIGH: begin
                if (!r_s2) begin
                    w_next_state   = ST_FALL_CHK;
                    w_next_deb_cnt = 3'd1;
                end
            end
            ST_FALL_CHK: begin
                if (r_s2) begin
                    w_next_state = ST_HIGH;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_next_state = ST_LOW;
                end else begin
                    w_next_deb_cnt = r_deb_cnt + 3'd1;
                end
            end
            default: begin
                w_next_state   = ST_LOW;
                w_next_deb_cnt = 3'd0;
            end
        endcase
    end

    // FSM outputs: filtered level plus arrival/departure strobes taken from transitions
    always_comb begin
        w_green     = (cntry == CNTRY_GREEN);
        w_filtered  = (r_state == ST_HIGH) || (r_state == ST_FALL_CHK);
        w_arrival   = (r_state == ST_RISE_CHK) && (w_next_state == ST_HIGH);
        w_departure = (r_state == ST_FALL_CHK) && (w_next_state == ST_LOW) && w_green;
    end

    assign w_demand    = w_filtered || (r_car_count != 4'd0);
    assign w_fault_set = !r_fault && (r_stuck_cnt == STUCK_MAX);

    // Car counter saturating at 0 and 15; forced to 0 once the sensor is declared stuck
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_car_count <= 4'd0;
        end else if (r_fault || w_fault_set) begin
            r_car_count <= 4'd0;
        end else if (w_arrival && (r_car_count != 4'd15)) begin
            r_car_count <= r_car_count + 4'd1;
        end else if (w_departure && (r_car_count != 4'd0)) begin
            r_car_count <= r_car_count - 4'd1;
        end
    end

    // Hold timer keeps X up for HOLD edges after demand disappears
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_hold_cnt <= 4'd0;
        end else if (r_fault || w_fault_set) begin
            r_hold_cnt <= 4'd0;
        end else if (w_demand) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if (r_hold_cnt != 4'd0) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
        end
    end

    // Stuck detector: a car cannot sit on the loop through a long green; fault is sticky
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_stuck_cnt <= 7'd0;
            r_fault     <= 1'b0;
        end else begin
            if (w_filtered && w_green) begin
                if (r_stuck_cnt != STUCK_MAX) begin
                    r_stuck_cnt <= r_stuck_cnt + 7'd1;
                end
            end else begin
                r_stuck_cnt <= 7'd0;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign X         = !r_fault && (w_demand || (r_hold_cnt != 4'd0));
    assign car_count = r_car_count;
    assign fault     = r_fault;

endmodule

// File: tb/tb_car_detect.sv
// Purpose: directed self-checking bench for car_detect using an expectation queue.
// Latency: expectations are queued at drive time and popped #1 after the edge they target.
// Backpressure: not applicable; the bench owns every input.
module tb_car_detect;

    logic       clock;
    logic       clear_n;
    logic       loop_in;
    logic [1:0] cntry;
    logic       X;
    logic [3:0] car_count;
    logic       fault;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic       x;
        logic       flt;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    car_detect dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .loop_in   (loop_in),
        .cntry     (cntry),
        .X         (X),
        .car_count (car_count),
        .fault     (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] cnt, input logic x, input logic flt);
        exp_t e;
        e.tag = tag;
        e.cnt = cnt;
        e.x   = x;
        e.flt = flt;
        q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (q.size() == 0) begin
            miscompares++;
            vectors++;
            $display("FAIL empty_queue: no expectation queued");
        end else begin
            e = q.pop_front();
            vectors++;
            assert ({car_count, X, fault} === {e.cnt, e.x, e.flt})
            else begin
                miscompares++;
                $error("FAIL %s: got car_count=%0d X=%b fault=%b, want car_count=%0d X=%b fault=%b",
                       e.tag, car_count, X, fault, e.cnt, e.x, e.flt);
            end
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        loop_in = 1'b0;
        cntry   = RED;
        tick(2);
        clear_n = 1'b1;
    endtask

    // one clean car: high 8 edges, low 8 edges, with chosen light during each half
    task automatic pulse(input logic [1:0] c_high, input logic [1:0] c_low);
        cntry   = c_high;
        loop_in = 1'b1;
        tick(8);
        cntry   = c_low;
        loop_in = 1'b0;
        tick(8);
    endtask

    initial begin
        clear_n = 1'b0;
        loop_in = 1'b0;
        cntry   = RED;
        #1;
        push("reset_state", 4'd0, 1'b0, 1'b0);
        check();
        tick(1);
        clear_n = 1'b1;

        // clean pulse; light changes mid-debounce must not disturb the qualification
        push("rise_edge5", 4'd0, 1'b0, 1'b0);
        push("rise_edge6", 4'd1, 1'b1, 1'b0);
        push("held_after_fall_c3", 4'd1, 1'b1, 1'b0);
        loop_in = 1'b1;
        tick(3);
        cntry = YELLOW;
        tick(2);
        check();
        cntry = 2'd3;
        tick(1);
        check();
        tick(14);
        loop_in = 1'b0;
        tick(30);
        check();

        // departure on green followed by the hold window
        do_reset();
        push("dep_setup", 4'd1, 1'b1, 1'b0);
        push("dep_edge5", 4'd1, 1'b1, 1'b0);
        push("dep_edge6", 4'd0, 1'b1, 1'b0);
        push("hold_edge13", 4'd0, 1'b1, 1'b0);
        push("hold_edge14", 4'd0, 1'b0, 1'b0);
        loop_in = 1'b1;
        tick(10);
        check();
        cntry   = GREEN;
        loop_in = 1'b0;
        tick(5);
        check();
        tick(1);
        check();
        tick(7);
        check();
        tick(1);
        check();

        // bounce rejection: single-cycle glitches every third cycle
        do_reset();
        for (int i = 0; i < 30; i++) begin
            loop_in = (i % 3 == 0);
            push("bounce", 4'd0, 1'b0, 1'b0);
            tick(1);
            check();
        end
        loop_in = 1'b0;

        // saturation at 15, then departures; each green pulse re-arrives at the ceiling first
        do_reset();
        push("sat_15_after_15", 4'd15, 1'b1, 1'b0);
        push("sat_15_after_17", 4'd15, 1'b1, 1'b0);
        push("sat_dep1", 4'd14, 1'b1, 1'b0);
        push("sat_dep2", 4'd14, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) pulse(RED, RED);
        check();
        pulse(RED, RED);
        pulse(RED, RED);
        check();
        pulse(RED, GREEN);
        check();
        pulse(RED, GREEN);
        check();

        // stuck sensor: held high through green
        do_reset();
        push("stuck_arrive", 4'd1, 1'b1, 1'b0);
        push("stuck_edge106", 4'd1, 1'b1, 1'b0);
        push("stuck_edge107", 4'd0, 1'b0, 1'b1);
        push("stuck_sticky", 4'd0, 1'b0, 1'b1);
        push("fault_blocks_count", 4'd0, 1'b0, 1'b1);
        push("fault_cleared", 4'd0, 1'b0, 1'b0);
        cntry   = GREEN;
        loop_in = 1'b1;
        tick(6);
        check();
        tick(100);
        check();
        tick(1);
        check();
        tick(10);
        check();
        loop_in = 1'b0;
        cntry   = RED;
        tick(10);
        pulse(RED, RED);
        check();
        clear_n = 1'b0;
        #1;
        check();
        tick(1);
        clear_n = 1'b1;

        // asynchronous reset between edges while X=1 and car_count=3
        do_reset();
        push("three_cars", 4'd3, 1'b1, 1'b0);
        push("async_clear", 4'd0, 1'b0, 1'b0);
        push("post_rst_edge5", 4'd0, 1'b0, 1'b0);
        push("post_rst_edge6", 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(RED, RED);
        check();
        #3;
        clear_n = 1'b0;
        #1;
        check();
        loop_in = 1'b1;
        tick(1);
        clear_n = 1'b1;
        tick(5);
        check();
        tick(1);
        check();

        // reset mid-debounce discards the partial qualification
        do_reset();
        push("mid_deb_discard", 4'd0, 1'b0, 1'b0);
        loop_in = 1'b1;
        tick(4);
        clear_n = 1'b0;
        loop_in = 1'b0;
        tick(1);
        clear_n = 1'b1;
        tick(12);
        check();

        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_queue: %0d expectations never checked, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
